// File: rtl/display_arbiter.sv
// Display source arbiter: selects TIME, ALRM or a held MSG for a 4-digit display
// and blanks one digit on a blink cadence while editing.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 200000000,
  parameter int unsigned BLINK_HALF  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] time_d0,
  input  logic [3:0] time_d1,
  input  logic [3:0] time_d2,
  input  logic [3:0] time_d3,
  input  logic       alrm_req,
  input  logic [3:0] alrm_d0,
  input  logic [3:0] alrm_d1,
  input  logic [3:0] alrm_d2,
  input  logic [3:0] alrm_d3,
  input  logic       msg_req,
  input  logic [3:0] msg_d0,
  input  logic [3:0] msg_d1,
  input  logic [3:0] msg_d2,
  input  logic [3:0] msg_d3,
  input  logic       edit_en,
  input  logic [1:0] edit_digit,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic [3:0] blank,
  output logic [1:0] src,
  output logic       msg_ack
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    StTime = 2'd0,
    StAlrm = 2'd1,
    StMsg  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_off_q, phase_off_d;
  logic              edit_en_q;
  logic [15:0]       msg_buf_q, msg_buf_d;
  logic [15:0]       disp_q, disp_d;
  logic [3:0]        blank_q, blank_d;
  logic [1:0]        src_q, src_d;
  logic              ack_q, ack_d;

  // Source FSM; a new message request always wins, including on the hold-expiry cycle.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    msg_buf_d = msg_buf_q;
    ack_d     = 1'b0;
    if (msg_req) begin
      state_d   = StMsg;
      hold_d    = '0;
      msg_buf_d = {msg_d3, msg_d2, msg_d1, msg_d0};
      ack_d     = 1'b1;
    end else begin
      case (state_q)
        StTime: if (alrm_req) state_d = StAlrm;
        StAlrm: if (!alrm_req) state_d = StTime;
        StMsg: begin
          if (hold_q == HoldMax) begin
            hold_d  = '0;
            state_d = alrm_req ? StAlrm : StTime;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = StTime;
      endcase
    end
  end

  // Blink timebase; an edit_en rising edge restarts it in the ON phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_off_d = phase_off_q;
    if (edit_en && !edit_en_q) begin
      blink_cnt_d = '0;
      phase_off_d = 1'b0;
    end else if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d = '0;
      phase_off_d = ~phase_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Outputs are computed from next state so digits and src land on the same edge.
  always_comb begin
    case (state_d)
      StAlrm:  disp_d = {alrm_d3, alrm_d2, alrm_d1, alrm_d0};
      StMsg:   disp_d = msg_buf_d;
      default: disp_d = {time_d3, time_d2, time_d1, time_d0};
    endcase
    src_d   = state_d;
    blank_d = '0;
    if (edit_en && phase_off_d && (state_d != StMsg)) blank_d[edit_digit] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StTime;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_off_q <= 1'b0;
      edit_en_q   <= 1'b0;
      msg_buf_q   <= '0;
      disp_q      <= '0;
      blank_q     <= '0;
      src_q       <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_off_q <= phase_off_d;
      edit_en_q   <= edit_en;
      msg_buf_q   <= msg_buf_d;
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      src_q       <= src_d;
      ack_q       <= ack_d;
    end
  end

  assign disp_d0 = disp_q[3:0];
  assign disp_d1 = disp_q[7:4];
  assign disp_d2 = disp_q[11:8];
  assign disp_d3 = disp_q[15:12];
  assign blank   = blank_q;
  assign src     = src_q;
  assign msg_ack = ack_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: stimulus queues expected outputs per clock,
// a negedge monitor pops and compares them.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] time_v = 16'h4321;
  logic [15:0] alrm_v = 16'h0307;
  logic [15:0] msg_v  = 16'h0000;
  logic        alrm_req = 1'b0;
  logic        msg_req  = 1'b0;
  logic        edit_en  = 1'b0;
  logic [1:0]  edit_digit = 2'd0;
  logic [3:0]  disp_d0, disp_d1, disp_d2, disp_d3;
  logic [3:0]  blank;
  logic [1:0]  src;
  logic        msg_ack;

  typedef struct packed {
    logic [15:0] disp;
    logic [3:0]  blank;
    logic [1:0]  src;
    logic        ack;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  localparam logic [15:0] T = 16'h4321;
  localparam logic [15:0] A = 16'h0307;

  display_arbiter #(.HOLD_CYCLES(10), .BLINK_HALF(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .time_d0    (time_v[3:0]),
    .time_d1    (time_v[7:4]),
    .time_d2    (time_v[11:8]),
    .time_d3    (time_v[15:12]),
    .alrm_req   (alrm_req),
    .alrm_d0    (alrm_v[3:0]),
    .alrm_d1    (alrm_v[7:4]),
    .alrm_d2    (alrm_v[11:8]),
    .alrm_d3    (alrm_v[15:12]),
    .msg_req    (msg_req),
    .msg_d0     (msg_v[3:0]),
    .msg_d1     (msg_v[7:4]),
    .msg_d2     (msg_v[11:8]),
    .msg_d3     (msg_v[15:12]),
    .edit_en    (edit_en),
    .edit_digit (edit_digit),
    .disp_d0    (disp_d0),
    .disp_d1    (disp_d1),
    .disp_d2    (disp_d2),
    .disp_d3    (disp_d3),
    .blank      (blank),
    .src        (src),
    .msg_ack    (msg_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e, input string n);
    exp_t act;
    act = '{disp: {disp_d3, disp_d2, disp_d1, disp_d0}, blank: blank, src: src, ack: msg_ack};
    n_checks++;
    if (act !== e) begin
      n_fails++;
      $display("FAIL %s @%0t: got disp=%h blank=%b src=%0d ack=%b, want disp=%h blank=%b src=%0d ack=%b",
               n, $time, act.disp, act.blank, act.src, act.ack, e.disp, e.blank, e.src, e.ack);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check(exp_q.pop_front(), name_q.pop_front());
  end

  // Inputs already set; expectation is for the outputs after the coming edge.
  task automatic cyc(input logic [15:0] d, input logic [3:0] b, input logic [1:0] s,
                     input logic a, input string n);
    @(posedge clk);
    exp_q.push_back('{disp: d, blank: b, src: s, ack: a});
    name_q.push_back(n);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check('{disp: 16'h0, blank: 4'h0, src: 2'd0, ack: 1'b0}, "reset_state");
    rst = 1'b0;

    repeat (2) cyc(T, 4'b0000, 2'd0, 1'b0, "time_after_reset");

    alrm_req = 1'b1;
    repeat (3) cyc(A, 4'b0000, 2'd1, 1'b0, "alrm_shown");
    alrm_req = 1'b0;
    repeat (2) cyc(T, 4'b0000, 2'd0, 1'b0, "alrm_to_time");

    // Single message, live digits change after acceptance.
    msg_req = 1'b1; msg_v = 16'hEEEE;
    cyc(16'hEEEE, 4'b0000, 2'd2, 1'b1, "msg_accept");
    msg_req = 1'b0; msg_v = 16'h5555;
    repeat (9) cyc(16'hEEEE, 4'b0000, 2'd2, 1'b0, "msg_hold");
    cyc(T, 4'b0000, 2'd0, 1'b0, "msg_expire_time");

    // Retrigger 6 cycles in, returning to ALRM.
    alrm_req = 1'b1;
    msg_req = 1'b1; msg_v = 16'h1111;
    cyc(16'h1111, 4'b0000, 2'd2, 1'b1, "msg2_accept");
    msg_req = 1'b0;
    repeat (5) cyc(16'h1111, 4'b0000, 2'd2, 1'b0, "msg2_hold");
    msg_req = 1'b1; msg_v = 16'h2222;
    cyc(16'h2222, 4'b0000, 2'd2, 1'b1, "msg2_retrigger");
    msg_req = 1'b0;
    repeat (9) cyc(16'h2222, 4'b0000, 2'd2, 1'b0, "msg2_rehold");
    cyc(A, 4'b0000, 2'd1, 1'b0, "msg2_expire_alrm");

    // Retrigger exactly on the expiry cycle.
    msg_req = 1'b1; msg_v = 16'h3333;
    cyc(16'h3333, 4'b0000, 2'd2, 1'b1, "msg3_accept");
    msg_req = 1'b0;
    repeat (9) cyc(16'h3333, 4'b0000, 2'd2, 1'b0, "msg3_hold");
    msg_req = 1'b1; msg_v = 16'h4444;
    cyc(16'h4444, 4'b0000, 2'd2, 1'b1, "msg3_expiry_retrigger");
    msg_req = 1'b0;
    repeat (9) cyc(16'h4444, 4'b0000, 2'd2, 1'b0, "msg3_rehold");
    alrm_req = 1'b0;
    cyc(T, 4'b0000, 2'd0, 1'b0, "msg3_expire_time");

    // Blink on digit 2.
    edit_en = 1'b1; edit_digit = 2'd2;
    repeat (4) cyc(T, 4'b0000, 2'd0, 1'b0, "blink_on0");
    repeat (4) cyc(T, 4'b0100, 2'd0, 1'b0, "blink_off0");
    repeat (4) cyc(T, 4'b0000, 2'd0, 1'b0, "blink_on1");
    repeat (2) cyc(T, 4'b0100, 2'd0, 1'b0, "blink_off1");
    msg_req = 1'b1; msg_v = 16'h6666;
    cyc(16'h6666, 4'b0000, 2'd2, 1'b1, "blink_msg_accept");
    msg_req = 1'b0;
    repeat (9) cyc(16'h6666, 4'b0000, 2'd2, 1'b0, "blink_msg_noblank");
    repeat (4) cyc(T, 4'b0000, 2'd0, 1'b0, "blink_after_msg_on");
    cyc(T, 4'b0100, 2'd0, 1'b0, "blink_after_msg_off");
    edit_digit = 2'd0;
    repeat (3) cyc(T, 4'b0001, 2'd0, 1'b0, "blink_digit_change");
    cyc(T, 4'b0000, 2'd0, 1'b0, "blink_digit_change_on");
    edit_en = 1'b0;
    cyc(T, 4'b0000, 2'd0, 1'b0, "edit_off");

    // Asynchronous reset mid-period during MSG.
    msg_req = 1'b1; msg_v = 16'h7777;
    cyc(16'h7777, 4'b0000, 2'd2, 1'b1, "msg4_accept");
    msg_req = 1'b0;
    repeat (2) cyc(16'h7777, 4'b0000, 2'd2, 1'b0, "msg4_hold");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check('{disp: 16'h0, blank: 4'h0, src: 2'd0, ack: 1'b0}, "async_reset_immediate");
    @(posedge clk);
    #1;
    check('{disp: 16'h0, blank: 4'h0, src: 2'd0, ack: 1'b0}, "async_reset_held");
    rst = 1'b0;
    time_v = 16'h9876;
    cyc(16'h9876, 4'b0000, 2'd0, 1'b0, "resume_time");
    cyc(16'h9876, 4'b0000, 2'd0, 1'b0, "resume_time2");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
